// File: rtl/arm_multicycle_ctrl_if.sv
// Controller <-> instruction register / datapath signal bundle.
// master = control unit, slave = datapath side.
interface arm_multicycle_ctrl_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite;
    logic       AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags;
    logic [3:0] State;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Flags, State
    );
    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Flags, State
    );
endinterface

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM-subset control FSM: sequences fetch/decode/execute/memory/writeback,
// owns the NZCV register and evaluates the condition field.
module arm_multicycle_ctrl #(
    parameter bit         EXT_OPS     = 1'b1,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    arm_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                           ALU_ORR = 3'b011, ALU_EOR = 3'b100;

    state_t     state, state_nx;
    logic [3:0] flags;
    logic       n, z, c, v;
    logic       condex_live, condex_q, condex;
    logic       dp_ok, nowrite, cv_upd;
    logic [2:0] dp_ctl;
    logic       pcw, regw, memw, irw, wb;

    assign {n, z, c, v} = flags;

    always_comb begin
        case (bus.Cond)
            4'b0000: condex_live = z;
            4'b0001: condex_live = ~z;
            4'b0010: condex_live = c;
            4'b0011: condex_live = ~c;
            4'b0100: condex_live = n;
            4'b0101: condex_live = ~n;
            4'b0110: condex_live = v;
            4'b0111: condex_live = ~v;
            4'b1000: condex_live = c & ~z;
            4'b1001: condex_live = ~c | z;
            4'b1010: condex_live = (n == v);
            4'b1011: condex_live = (n != v);
            4'b1100: condex_live = ~z & (n == v);
            4'b1101: condex_live = z | (n != v);
            4'b1110: condex_live = 1'b1;
            default: condex_live = 1'b0;
        endcase
    end

    // ALUWB sees flags already updated by its own EXECUTE, so it uses the
    // condition result captured during EXECUTE instead.
    assign condex = (state == ALUWB) ? condex_q : condex_live;

    always_comb begin
        dp_ok   = 1'b1;
        dp_ctl  = ALU_ADD;
        nowrite = 1'b0;
        cv_upd  = 1'b0;
        case (bus.Funct[4:1])
            4'b0100: begin dp_ctl = ALU_ADD; cv_upd = 1'b1; end
            4'b0010: begin dp_ctl = ALU_SUB; cv_upd = 1'b1; end
            4'b0000: dp_ctl = ALU_AND;
            4'b1100: dp_ctl = ALU_ORR;
            4'b0001: if (EXT_OPS) dp_ctl = ALU_EOR; else dp_ok = 1'b0;
            4'b1010: if (EXT_OPS) begin dp_ctl = ALU_SUB; nowrite = 1'b1; cv_upd = 1'b1; end
                     else dp_ok = 1'b0;
            4'b1000: if (EXT_OPS) begin dp_ctl = ALU_AND; nowrite = 1'b1; end
                     else dp_ok = 1'b0;
            4'b1011: if (EXT_OPS) begin dp_ctl = ALU_ADD; nowrite = 1'b1; cv_upd = 1'b1; end
                     else dp_ok = 1'b0;
            default: dp_ok = 1'b0;
        endcase
        if (!dp_ok) begin
            dp_ctl  = ALU_ADD;
            nowrite = 1'b1;
            cv_upd  = 1'b0;
        end
        // Memory writeback shares the rule but has no NoWrite notion.
        if (bus.Op != 2'b00) nowrite = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= FETCH;
        else          state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags    <= RESET_FLAGS;
            condex_q <= 1'b0;
        end else begin
            condex_q <= condex_live;
            if ((state == EXECUTER || state == EXECUTEI) && condex_live && bus.Funct[0] && dp_ok) begin
                flags[3:2] <= bus.ALUFlags[3:2];
                if (cv_upd) flags[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        state_nx       = FETCH;
        pcw            = 1'b0;
        regw           = 1'b0;
        memw           = 1'b0;
        irw            = 1'b0;
        wb             = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ALUControl = ALU_ADD;
        case (state)
            FETCH: begin
                state_nx      = DECODE;
                irw           = 1'b1;
                pcw           = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            DECODE: begin
                case (bus.Op)
                    2'b00:   state_nx = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_nx = MEMADR;
                    2'b10:   state_nx = BRANCH;
                    default: state_nx = FETCH;
                endcase
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            MEMADR: begin
                state_nx    = bus.Funct[0] ? MEMRD : MEMWR;
                bus.ALUSrcB = 2'b01;
            end
            MEMRD: begin
                state_nx   = MEMWB;
                bus.AdrSrc = 1'b1;
            end
            MEMWR: begin
                bus.AdrSrc = 1'b1;
                memw       = condex;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                wb            = 1'b1;
            end
            EXECUTER: begin
                state_nx       = ALUWB;
                bus.ALUControl = dp_ctl;
            end
            EXECUTEI: begin
                state_nx       = ALUWB;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = dp_ctl;
            end
            ALUWB: wb = 1'b1;
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                pcw           = condex;
            end
            default: state_nx = FETCH;
        endcase
        if (wb) begin
            if (bus.Rd == 4'hF) pcw  = condex;
            else                regw = condex & ~nowrite;
        end
    end

    // Enables are forced low while reset is held so an aborted instruction never writes.
    assign bus.PCWrite  = pcw  & reset_n;
    assign bus.RegWrite = regw & reset_n;
    assign bus.MemWrite = memw & reset_n;
    assign bus.IRWrite  = irw  & reset_n;
    assign bus.ImmSrc   = bus.Op;
    assign bus.RegSrc   = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.Flags    = flags;
    assign bus.State    = state;
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Bench for arm_multicycle_ctrl: directed table, reset corner case, and random
// instructions checked against an instruction-level reference model on two configs.
module tb_arm_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] cond = '0, rd = '0, aluflags = '0;
    logic [1:0] op = '0;
    logic [5:0] funct = '0;

    arm_multicycle_ctrl_if b1();
    arm_multicycle_ctrl_if b0();
    assign b1.Cond = cond; assign b1.Op = op; assign b1.Funct = funct;
    assign b1.Rd = rd;     assign b1.ALUFlags = aluflags;
    assign b0.Cond = cond; assign b0.Op = op; assign b0.Funct = funct;
    assign b0.Rd = rd;     assign b0.ALUFlags = aluflags;

    localparam logic [3:0] RF0 = 4'b0100;
    arm_multicycle_ctrl #(.EXT_OPS(1'b1), .RESET_FLAGS(4'b0000)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    arm_multicycle_ctrl #(.EXT_OPS(1'b0), .RESET_FLAGS(RF0))     dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));

    typedef struct packed {
        logic [3:0] cond; logic [1:0] op; logic [5:0] funct; logic [3:0] rd; logic [3:0] af;
    } ins_t;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, regw, memw, irw, adr, srca;
        logic [1:0] srcb, res, imm, regsrc;
        logic [2:0] alu;
        logic [3:0] fl;
    } exp_t;

    typedef struct packed {
        ins_t       i;
        logic [19:0] sts;
        logic [2:0] len;
        logic [4:0] pcw, regw, memw;
        logic [3:0] fl;
    } vec_t;

    int errors = 0, checks = 0;
    exp_t seq [2][5];
    int   mlen;
    logic [3:0] mf1 = 4'b0000, mf0 = RF0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ARM condition semantics: even codes test a predicate, odd codes its negation.
    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit fn, fz, fc, fv, base;
        {fn, fz, fc, fv} = f;
        case (cc[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc && !fz;
            3'd5: base = (fn == fv);
            3'd6: base = !fz && (fn == fv);
            default: base = 1'b1;
        endcase
        if (cc == 4'hE) return 1'b1;
        if (cc == 4'hF) return 1'b0;
        return cc[0] ? !base : base;
    endfunction

    // Returns {supported, alu[2:0], nowrite, loads_cv}
    function automatic logic [5:0] dp_model(input logic [3:0] cmd, input bit ext);
        case (cmd)
            4'b0100: return {1'b1, 3'd0, 1'b0, 1'b1};
            4'b0010: return {1'b1, 3'd1, 1'b0, 1'b1};
            4'b0000: return {1'b1, 3'd2, 1'b0, 1'b0};
            4'b1100: return {1'b1, 3'd3, 1'b0, 1'b0};
            4'b0001: if (ext) return {1'b1, 3'd4, 1'b0, 1'b0};
            4'b1010: if (ext) return {1'b1, 3'd1, 1'b1, 1'b1};
            4'b1000: if (ext) return {1'b1, 3'd2, 1'b1, 1'b0};
            4'b1011: if (ext) return {1'b1, 3'd0, 1'b1, 1'b1};
            default: ;
        endcase
        return {1'b0, 3'd0, 1'b1, 1'b0};
    endfunction

    function automatic exp_t base_exp(input ins_t i, input logic [3:0] fl);
        exp_t e;
        e = '0;
        e.imm    = i.op;
        e.regsrc = {i.op == 2'b01, i.op == 2'b10};
        e.fl     = fl;
        return e;
    endfunction

    // Expected per-cycle outputs of one whole instruction, and the flags it leaves behind.
    task automatic build(input ins_t i, input bit ext, input logic [3:0] fl, output logic [3:0] fa);
        exp_t e;
        bit ce;
        logic [5:0] d;
        ce = cond_ok(i.cond, fl);
        fa = fl;
        e = base_exp(i, fl);
        e.st = 4'd0; e.pcw = 1; e.irw = 1; e.srca = 1; e.srcb = 2'b10; e.res = 2'b10;
        seq[ext][0] = e;
        e = base_exp(i, fl);
        e.st = 4'd1; e.srca = 1; e.srcb = 2'b10; e.res = 2'b10;
        seq[ext][1] = e;
        mlen = 2;
        case (i.op)
            2'b00: begin
                d = dp_model(i.funct[4:1], ext);
                e = base_exp(i, fl);
                e.st = i.funct[5] ? 4'd7 : 4'd6; e.srcb = i.funct[5] ? 2'b01 : 2'b00; e.alu = d[4:2];
                seq[ext][2] = e;
                if (ce && i.funct[0] && d[5]) begin
                    fa[3:2] = i.af[3:2];
                    if (d[0]) fa[1:0] = i.af[1:0];
                end
                e = base_exp(i, fa);
                e.st = 4'd8;
                if (i.rd == 4'hF) e.pcw = ce; else e.regw = ce && !d[1];
                seq[ext][3] = e;
                mlen = 4;
            end
            2'b01: begin
                e = base_exp(i, fl);
                e.st = 4'd2; e.srcb = 2'b01;
                seq[ext][2] = e;
                e = base_exp(i, fl);
                e.adr = 1;
                if (i.funct[0]) begin
                    e.st = 4'd3;
                    seq[ext][3] = e;
                    e = base_exp(i, fl);
                    e.st = 4'd4; e.res = 2'b01;
                    if (i.rd == 4'hF) e.pcw = ce; else e.regw = ce;
                    seq[ext][4] = e;
                    mlen = 5;
                end else begin
                    e.st = 4'd5; e.memw = ce;
                    seq[ext][3] = e;
                    mlen = 4;
                end
            end
            2'b10: begin
                e = base_exp(i, fl);
                e.st = 4'd9; e.srcb = 2'b01; e.res = 2'b10; e.pcw = ce;
                seq[ext][2] = e;
                mlen = 3;
            end
            default: ;
        endcase
    endtask

    function automatic exp_t act1();
        exp_t e;
        e = {b1.State, b1.PCWrite, b1.RegWrite, b1.MemWrite, b1.IRWrite, b1.AdrSrc, b1.ALUSrcA,
             b1.ALUSrcB, b1.ResultSrc, b1.ImmSrc, b1.RegSrc, b1.ALUControl, b1.Flags};
        return e;
    endfunction

    function automatic exp_t act0();
        exp_t e;
        e = {b0.State, b0.PCWrite, b0.RegWrite, b0.MemWrite, b0.IRWrite, b0.AdrSrc, b0.ALUSrcA,
             b0.ALUSrcB, b0.ResultSrc, b0.ImmSrc, b0.RegSrc, b0.ALUControl, b0.Flags};
        return e;
    endfunction

    // Starts with both DUTs in FETCH just after a rising edge; ends the same way.
    task automatic run_instr(input ins_t i, input bit tab, input vec_t v);
        logic [3:0] fa1, fa0;
        int n;
        cond = i.cond; op = i.op; funct = i.funct; rd = i.rd; aluflags = i.af;
        build(i, 1'b0, mf0, fa0);
        build(i, 1'b1, mf1, fa1);
        n = tab ? int'(v.len) : mlen;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("ext1 cycle%0d", k), 32'(act1()), 32'(seq[1][k]));
            chk($sformatf("ext0 cycle%0d", k), 32'(act0()), 32'(seq[0][k]));
            if (tab) begin
                chk($sformatf("tab state c%0d", k), 32'(b1.State),    32'(v.sts[4*k +: 4]));
                chk($sformatf("tab pcw c%0d", k),   32'(b1.PCWrite),  32'(v.pcw[k]));
                chk($sformatf("tab regw c%0d", k),  32'(b1.RegWrite), 32'(v.regw[k]));
                chk($sformatf("tab memw c%0d", k),  32'(b1.MemWrite), 32'(v.memw[k]));
            end
            @(posedge clk); #1;
        end
        mf1 = fa1; mf0 = fa0;
        if (tab) begin
            chk("tab next state", 32'(b1.State), 32'd0);
            chk("tab flags",      32'(b1.Flags), 32'(v.fl));
        end
    endtask

    function automatic vec_t mk(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                                input logic [3:0] r, input logic [3:0] a, input logic [19:0] s,
                                input logic [2:0] l, input logic [4:0] pw, input logic [4:0] rw,
                                input logic [4:0] mw, input logic [3:0] fl);
        vec_t v;
        v.i = '{c, o, f, r, a};
        v.sts = s; v.len = l; v.pcw = pw; v.regw = rw; v.memw = mw; v.fl = fl;
        return v;
    endfunction

    vec_t tab [11];

    initial begin
        ins_t r;
        vec_t none;
        none = '0;
        // Directed table (dut1 expectations); sts holds one state nibble per cycle, cycle 0 lowest.
        tab[0]  = mk(4'hE, 2'd0, 6'b001000, 4'd1, 4'b0000, 20'h08610, 3'd4, 5'b00001, 5'b01000, 5'b0, 4'b0000); // ADD
        tab[1]  = mk(4'hE, 2'd0, 6'b100101, 4'd3, 4'b0110, 20'h08710, 3'd4, 5'b00001, 5'b01000, 5'b0, 4'b0110); // SUBS imm
        tab[2]  = mk(4'h0, 2'd2, 6'b000000, 4'd0, 4'b0000, 20'h00910, 3'd3, 5'b00101, 5'b00000, 5'b0, 4'b0110); // BEQ
        tab[3]  = mk(4'h1, 2'd2, 6'b000000, 4'd0, 4'b0000, 20'h00910, 3'd3, 5'b00001, 5'b00000, 5'b0, 4'b0110); // BNE
        tab[4]  = mk(4'hE, 2'd1, 6'b011001, 4'd2, 4'b0000, 20'h43210, 3'd5, 5'b00001, 5'b10000, 5'b0, 4'b0110); // LDR
        tab[5]  = mk(4'hE, 2'd1, 6'b011000, 4'd2, 4'b0000, 20'h05210, 3'd4, 5'b00001, 5'b00000, 5'b01000, 4'b0110); // STR
        tab[6]  = mk(4'hE, 2'd0, 6'b010101, 4'd0, 4'b1001, 20'h08610, 3'd4, 5'b00001, 5'b00000, 5'b0, 4'b1001); // CMP
        tab[7]  = mk(4'hE, 2'd0, 6'b001000, 4'hF, 4'b0000, 20'h08610, 3'd4, 5'b01001, 5'b00000, 5'b0, 4'b1001); // ADD pc
        tab[8]  = mk(4'hF, 2'd0, 6'b001001, 4'hF, 4'b0110, 20'h08610, 3'd4, 5'b00001, 5'b00000, 5'b0, 4'b1001); // never
        tab[9]  = mk(4'hE, 2'd3, 6'b000000, 4'd0, 4'b0000, 20'h00010, 3'd2, 5'b00001, 5'b00000, 5'b0, 4'b1001); // Op=11
        tab[10] = mk(4'hA, 2'd0, 6'b000011, 4'd4, 4'b1111, 20'h08610, 3'd4, 5'b00001, 5'b01000, 5'b0, 4'b1101); // EORS GE

        // Reset: enables held low while reset_n=0, state and flags initialised.
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst state1", 32'(b1.State), 32'd0);
        chk("rst flags1", 32'(b1.Flags), 32'h0);
        chk("rst flags0", 32'(b0.Flags), 32'(RF0));
        chk("rst pcw1",   32'(b1.PCWrite), 32'd0);
        chk("rst irw1",   32'(b1.IRWrite), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int t = 0; t < 11; t++) run_instr(tab[t].i, 1'b1, tab[t]);

        // Reset while an LDR is in MEMRD: aborts, no writeback, flags restored.
        cond = 4'hE; op = 2'd1; funct = 6'b011001; rd = 4'd2; aluflags = 4'h0;
        repeat (3) begin @(posedge clk); #1; end
        chk("ldr pre-reset state", 32'(b1.State), 32'd3);
        reset_n = 1'b0;
        @(negedge clk);
        chk("ldr rst regw1", 32'(b1.RegWrite), 32'd0);
        chk("ldr rst regw0", 32'(b0.RegWrite), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        op = 2'd3;
        @(negedge clk);
        chk("ldr abort state", 32'(b1.State), 32'd0);
        chk("ldr abort flags1", 32'(b1.Flags), 32'h0);
        chk("ldr abort flags0", 32'(b0.Flags), 32'(RF0));
        chk("ldr abort regw", 32'(b1.RegWrite), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post-abort state", 32'(b1.State), 32'd1);
        chk("post-abort regw", 32'(b1.RegWrite), 32'd0);
        @(posedge clk); #1;
        mf1 = 4'b0000; mf0 = RF0;

        // Random instructions against the reference model.
        for (int t = 0; t < 250; t++) begin
            r.cond  = 4'($urandom_range(0, 15));
            r.op    = 2'($urandom_range(0, 3));
            r.funct = 6'($urandom_range(0, 63));
            r.rd    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            r.af    = 4'($urandom_range(0, 15));
            run_instr(r, 1'b0, none);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
